// File: rtl/tick_counter_gen.sv
// Rate-selectable tick generator driving an up/down modulo counter (0..WRAP_VAL).
// Optional TICKGEN_ONESHOT_EN: the counter stops at its terminal value instead of wrapping.
module tick_counter_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int CNT_W    = 4,
  parameter int WRAP_VAL = 10,
  parameter int DIV_W    = 28
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [2:0]       clk_speed,
  input  logic             run,
  input  logic             dir_down,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LP_WRAP = CNT_W'(WRAP_VAL);

  logic [2:0]       r_sel;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_wrap;

  logic             w_sel_change;
  logic             w_active;
  logic             w_step;
  logic             w_at_term;
  logic [CNT_W-1:0] w_count_step;
  logic [CNT_W-1:0] w_load_sat;

  // Reload value (PERIOD-1) for each rate select; hold selects park the divider at 0.
  function automatic logic [DIV_W-1:0] period_m1(input logic [2:0] sel);
    logic [DIV_W-1:0] p;
    case (sel)
      3'd0:    p = '0;
      3'd1:    p = DIV_W'(CLK_HZ - 1);
      3'd2:    p = DIV_W'(CLK_HZ / 2 - 1);
      3'd3:    p = DIV_W'(CLK_HZ / 4 - 1);
      3'd4:    p = DIV_W'(CLK_HZ / 10 - 1);
      default: p = '0;
    endcase
    return p;
  endfunction

  assign w_sel_change = (clk_speed != r_sel);
  assign w_active     = run && (r_sel < 3'd5);
  assign w_step       = !w_sel_change && w_active && (r_div == '0);

  assign w_at_term    = dir_down ? (r_count == '0) : (r_count == LP_WRAP);
  assign w_count_step = dir_down ? (w_at_term ? LP_WRAP : r_count - CNT_W'(1))
                                 : (w_at_term ? '0      : r_count + CNT_W'(1));
  assign w_load_sat   = (load_val > LP_WRAP) ? LP_WRAP : load_val;

  // A rate change restarts the divider with a full new period and suppresses that cycle's step.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sel <= 3'd0;
      r_div <= '0;
    end else if (w_sel_change) begin
      r_sel <= clk_speed;
      r_div <= period_m1(clk_speed);
    end else if (w_active) begin
      r_div <= (r_div == '0) ? period_m1(r_sel) : r_div - DIV_W'(1);
    end
  end

`ifdef TICKGEN_ONESHOT_EN
  logic r_done;
  logic r_done_dir;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_done_dir <= 1'b0;
    end else if (load) begin
      r_done <= 1'b0;
    end else if (w_step && !r_done && w_at_term) begin
      r_done     <= 1'b1;
      r_done_dir <= dir_down;
    end else if (r_done && (dir_down != r_done_dir)) begin
      r_done <= 1'b0;
    end
  end
`endif

  // Load wins over a coincident step; strobes default low every cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (load) begin
        r_count <= w_load_sat;
      end else if (w_step) begin
`ifdef TICKGEN_ONESHOT_EN
        if (!r_done) begin
          if (w_at_term) begin
            r_wrap <= 1'b1;
          end else begin
            r_count <= w_count_step;
            r_tick  <= 1'b1;
          end
        end
`else
        r_count <= w_count_step;
        r_tick  <= 1'b1;
        r_wrap  <= w_at_term;
`endif
      end
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_tick_counter_gen.sv
// Directed + randomized bench for tick_counter_gen against a cycle-count reference model.
// Also exercises the TICKGEN_ONESHOT_EN behaviour when that macro is defined.
module tb_tick_counter_gen;

  localparam int CLK_HZ   = 100;
  localparam int CNT_W    = 4;
  localparam int WRAP_VAL = 10;
  localparam int DIV_W    = 8;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic [2:0]       clk_speed;
  logic             run;
  logic             dir_down;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: selected rate, edges left until the next step, counter value.
  int m_sel;
  int m_left;
  int m_count;
  bit m_done;
  bit m_done_dir;
  bit exp_tick;
  bit exp_wrap;
  int n_ticks;
  int n_wraps;
  int first_tick;

  always #5 CLOCK_50 = ~CLOCK_50;

  tick_counter_gen #(
    .CLK_HZ  (CLK_HZ),
    .CNT_W   (CNT_W),
    .WRAP_VAL(WRAP_VAL),
    .DIV_W   (DIV_W)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clk_speed(clk_speed),
    .run      (run),
    .dir_down (dir_down),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap)
  );

  function automatic int period_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return CLK_HZ;
      2:       return CLK_HZ / 2;
      3:       return CLK_HZ / 4;
      4:       return CLK_HZ / 10;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel      = 0;
    m_left     = period_of(0);
    m_count    = 0;
    m_done     = 0;
    m_done_dir = 0;
    exp_tick   = 0;
    exp_wrap   = 0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit step;
    bit old_done;
    bit term;
    step     = 0;
    exp_tick = 0;
    exp_wrap = 0;
    old_done = m_done;
    if (int'(clk_speed) != m_sel) begin
      m_sel  = int'(clk_speed);
      m_left = period_of(m_sel);
    end else if (run && m_sel <= 4) begin
      m_left--;
      if (m_left == 0) begin
        step   = 1;
        m_left = period_of(m_sel);
      end
    end
    term = dir_down ? (m_count == 0) : (m_count == WRAP_VAL);
    if (load) begin
      m_count = (int'(load_val) > WRAP_VAL) ? WRAP_VAL : int'(load_val);
    end else if (step) begin
`ifdef TICKGEN_ONESHOT_EN
      if (!old_done) begin
        if (term) begin
          exp_wrap = 1;
        end else begin
          m_count  = dir_down ? m_count - 1 : m_count + 1;
          exp_tick = 1;
        end
      end
`else
      exp_wrap = term;
      exp_tick = 1;
      m_count  = dir_down ? (m_count + WRAP_VAL) % (WRAP_VAL + 1)
                          : (m_count + 1) % (WRAP_VAL + 1);
`endif
    end
    if (load) m_done = 0;
    else if (step && !old_done && term) begin
      m_done     = 1;
      m_done_dir = dir_down;
    end else if (old_done && (dir_down != m_done_dir)) m_done = 0;
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("count", 32'(count), 32'(m_count));
    check("tick", 32'(tick), 32'(exp_tick));
    check("wrap", 32'(wrap), 32'(exp_wrap));
    n_ticks += int'(tick);
    n_wraps += int'(wrap);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset     = 1'b1;
    clk_speed = 3'd4;
    run       = 1'b1;
    dir_down  = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    model_reset();
    #12;
    check("reset_count", 32'(count), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    reset = 1'b0;

    $display("step: sel=4 up, 111 cycles");
    n_ticks = 0; n_wraps = 0;
    cycles(111);
    check("sel4_ticks", 32'(n_ticks), 32'd11);
    check("sel4_wraps", 32'(n_wraps), 32'd1);
    check("sel4_count", 32'(count), 32'd0);

    $display("step: sel=1 for 40 cycles then sel=3");
    clk_speed = 3'd1;
    n_ticks = 0;
    cycles(40);
    check("sel1_no_ticks", 32'(n_ticks), 32'd0);
    clk_speed = 3'd3;
    first_tick = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (tick && first_tick == 0) first_tick = i;
    end
    check("sel3_first_tick", 32'(first_tick), 32'd26);

    $display("step: down count at sel=0 from 0");
    load = 1'b1; load_val = '0; clk_speed = 3'd0;
    cycle();
    load = 1'b0; dir_down = 1'b1;
    cycle();
    check("down_wrap_val", 32'(count), 32'd10);
    check("down_wrap_strobe", 32'(wrap), 32'd1);
    cycle();
    check("down_9", 32'(count), 32'd9);
    cycle();
    check("down_8", 32'(count), 32'd8);

    $display("step: saturating load on a tick edge, then pause");
    load = 1'b1; load_val = 4'd15;
    cycle();
    check("load_sat", 32'(count), 32'd10);
    check("load_no_tick", 32'(tick), 32'd0);
    load = 1'b0; dir_down = 1'b0; clk_speed = 3'd4;
    cycles(13);
    run = 1'b0;
    n_ticks = 0;
    cycles(7);
    check("pause_no_ticks", 32'(n_ticks), 32'd0);
    run = 1'b1;
    cycles(25);

    $display("step: hold select 6 for 300 cycles");
    clk_speed = 3'd6;
    n_ticks = 0;
    cycles(300);
    check("hold_no_ticks", 32'(n_ticks), 32'd0);

    $display("step: async reset mid-period");
    clk_speed = 3'd0;
    cycles(4);
    clk_speed = 3'd4;
    cycles(5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    cycles(20);

`ifdef TICKGEN_ONESHOT_EN
    $display("step: oneshot up at sel=0");
    load = 1'b1; load_val = '0; dir_down = 1'b0; clk_speed = 3'd0;
    cycle();
    load = 1'b0;
    n_wraps = 0;
    cycles(15);
    check("oneshot_hold", 32'(count), 32'd10);
    check("oneshot_wraps", 32'(n_wraps), 32'd1);
    load = 1'b1; load_val = 4'd3;
    cycle();
    check("oneshot_load", 32'(count), 32'd3);
    load = 1'b0;
    cycle();
    check("oneshot_resume", 32'(count), 32'd4);
`endif

    $display("step: randomized traffic, 800 cycles");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) clk_speed = 3'($urandom_range(0, 7));
      run      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) dir_down = ~dir_down;
      load     = ($urandom_range(0, 24) == 0);
      load_val = CNT_W'($urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
